// File: rtl/load_rs_issue_if.sv
// rtl/load_rs_issue_if.sv - dispatch, wake-up, issue and status signals of the load reservation station
interface load_rs_issue_if #(
  parameter int NUM_ENTRIES   = 4,
  parameter int NUM_PHYS_REGS = 64,
  parameter int PREG_W        = 6,
  parameter int ROB_W         = 5
);
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  logic                     flush;
  logic                     dispatch_valid;
  logic                     dispatch_ready;
  logic [ROB_W-1:0]         dispatch_rob_num;
  logic [PREG_W-1:0]        dispatch_ps1;
  logic [PREG_W-1:0]        dispatch_pd;
  logic [31:0]              dispatch_imm;
  logic [2:0]               dispatch_funct3;
  logic                     dispatch_has_store_dep;
  logic [ROB_W-1:0]         dispatch_store_dep;
  logic [NUM_PHYS_REGS-1:0] valid_reg;
  logic                     sl_cdb_valid;
  logic [ROB_W-1:0]         sl_cdb_rob_num;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [ROB_W-1:0]         issue_rob_num;
  logic [PREG_W-1:0]        issue_ps1;
  logic [PREG_W-1:0]        issue_pd;
  logic [31:0]              issue_imm;
  logic [2:0]               issue_funct3;
  logic [OCC_W-1:0]         occupancy;

  modport master (
    output flush, dispatch_valid, dispatch_rob_num, dispatch_ps1, dispatch_pd, dispatch_imm,
           dispatch_funct3, dispatch_has_store_dep, dispatch_store_dep, valid_reg,
           sl_cdb_valid, sl_cdb_rob_num, issue_ready,
    input  dispatch_ready, issue_valid, issue_rob_num, issue_ps1, issue_pd, issue_imm,
           issue_funct3, occupancy
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_rob_num, dispatch_ps1, dispatch_pd, dispatch_imm,
           dispatch_funct3, dispatch_has_store_dep, dispatch_store_dep, valid_reg,
           sl_cdb_valid, sl_cdb_rob_num, issue_ready,
    output dispatch_ready, issue_valid, issue_rob_num, issue_ps1, issue_pd, issue_imm,
           issue_funct3, occupancy
  );
endinterface

// File: rtl/load_rs_issue.sv
// rtl/load_rs_issue.sv - load reservation station: store/base-register wake-up and oldest-ready issue
module load_rs_issue #(
  parameter int NUM_ENTRIES   = 4,
  parameter int NUM_PHYS_REGS = 64,
  parameter int PREG_W        = 6,
  parameter int ROB_W         = 5
) (
  input logic          clk,
  input logic          rst,
  load_rs_issue_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT_STORE, ST_WAIT_REG, ST_READY} slot_state_t;

  slot_state_t             r_state     [NUM_ENTRIES];
  logic [ROB_W-1:0]        r_rob_num   [NUM_ENTRIES];
  logic [PREG_W-1:0]       r_ps1       [NUM_ENTRIES];
  logic [PREG_W-1:0]       r_pd        [NUM_ENTRIES];
  logic [31:0]             r_imm       [NUM_ENTRIES];
  logic [2:0]              r_funct3    [NUM_ENTRIES];
  logic [ROB_W-1:0]        r_store_dep [NUM_ENTRIES];
  // r_older[i][j] set means slot i was allocated before slot j
  logic [NUM_ENTRIES-1:0]  r_older     [NUM_ENTRIES];
  logic [OCC_W-1:0]        r_occ;

  logic [NUM_ENTRIES-1:0]  w_empty;
  logic [NUM_ENTRIES-1:0]  w_ready;
  logic [NUM_ENTRIES-1:0]  w_sel_oh;
  logic [IDX_W-1:0]        w_sel_idx;
  logic [IDX_W-1:0]        w_alloc_idx;
  logic                    w_alloc;
  logic                    w_issue;
  logic                    w_issue_valid;
  slot_state_t             w_disp_state;

  always_comb begin
    w_empty     = '0;
    w_ready     = '0;
    w_sel_oh    = '0;
    w_sel_idx   = '0;
    w_alloc_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_empty[i] = (r_state[i] == ST_EMPTY);
      w_ready[i] = (r_state[i] == ST_READY);
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_empty[i]) w_alloc_idx = IDX_W'(i);
    end
    // A ready slot wins only if it is older than every other ready slot
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_sel_oh[i] = w_ready[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && w_ready[j] && !r_older[i][j]) w_sel_oh[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_sel_oh[i]) w_sel_idx = IDX_W'(i);
    end
    if (bus.dispatch_has_store_dep &&
        !(bus.sl_cdb_valid && bus.sl_cdb_rob_num == bus.dispatch_store_dep))
      w_disp_state = ST_WAIT_STORE;
    else if (bus.valid_reg[bus.dispatch_ps1])
      w_disp_state = ST_READY;
    else
      w_disp_state = ST_WAIT_REG;
  end

  assign w_issue_valid = (|w_ready) && !bus.flush;
  assign w_alloc       = bus.dispatch_valid && (|w_empty) && !bus.flush;
  assign w_issue       = w_issue_valid && bus.issue_ready;

  assign bus.dispatch_ready = |w_empty;
  assign bus.issue_valid    = w_issue_valid;
  assign bus.issue_rob_num  = r_rob_num[w_sel_idx];
  assign bus.issue_ps1      = r_ps1[w_sel_idx];
  assign bus.issue_pd       = r_pd[w_sel_idx];
  assign bus.issue_imm      = r_imm[w_sel_idx];
  assign bus.issue_funct3   = r_funct3[w_sel_idx];
  assign bus.occupancy      = r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_state[i] <= ST_EMPTY;
        r_older[i] <= '0;
      end
      r_occ <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_state[i] <= ST_EMPTY;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_alloc && w_alloc_idx == IDX_W'(i)) begin
          r_state[i]     <= w_disp_state;
          r_rob_num[i]   <= bus.dispatch_rob_num;
          r_ps1[i]       <= bus.dispatch_ps1;
          r_pd[i]        <= bus.dispatch_pd;
          r_imm[i]       <= bus.dispatch_imm;
          r_funct3[i]    <= bus.dispatch_funct3;
          r_store_dep[i] <= bus.dispatch_store_dep;
          r_older[i]     <= '0;
        end else begin
          if (w_alloc && !w_empty[i]) r_older[i][w_alloc_idx] <= 1'b1;
          if (w_issue && w_sel_oh[i]) begin
            r_state[i] <= ST_EMPTY;
          end else begin
            unique case (r_state[i])
              ST_WAIT_STORE:
                if (bus.sl_cdb_valid && bus.sl_cdb_rob_num == r_store_dep[i]) r_state[i] <= ST_WAIT_REG;
              ST_WAIT_REG:
                if (bus.valid_reg[r_ps1[i]]) r_state[i] <= ST_READY;
              default: ;
            endcase
          end
        end
      end
      r_occ <= r_occ + OCC_W'(w_alloc) - OCC_W'(w_issue);
    end
  end
endmodule

// File: tb/tb_load_rs_issue.sv
// tb/tb_load_rs_issue.sv - directed self-checking bench for load_rs_issue
module tb_load_rs_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  load_rs_issue_if #(.NUM_ENTRIES(4), .NUM_PHYS_REGS(64), .PREG_W(6), .ROB_W(5)) bus ();

  load_rs_issue #(.NUM_ENTRIES(4), .NUM_PHYS_REGS(64), .PREG_W(6), .ROB_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic disp(input int rob, input int ps1, input int pd, input logic [31:0] imm,
                      input int f3, input logic has_dep, input int dep);
    bus.dispatch_valid         = 1'b1;
    bus.dispatch_rob_num       = 5'(rob);
    bus.dispatch_ps1           = 6'(ps1);
    bus.dispatch_pd            = 6'(pd);
    bus.dispatch_imm           = imm;
    bus.dispatch_funct3        = 3'(f3);
    bus.dispatch_has_store_dep = has_dep;
    bus.dispatch_store_dep     = 5'(dep);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_rob_num = '0;
    bus.dispatch_ps1 = '0;
    bus.dispatch_pd = '0;
    bus.dispatch_imm = '0;
    bus.dispatch_funct3 = '0;
    bus.dispatch_has_store_dep = 1'b0;
    bus.dispatch_store_dep = '0;
    bus.valid_reg = '0;
    bus.sl_cdb_valid = 1'b0;
    bus.sl_cdb_rob_num = '0;
    bus.issue_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    sample();
    check("rst_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    cyc();

    // Ready-on-dispatch load issues the following cycle
    bus.valid_reg[5] = 1'b1;
    bus.issue_ready = 1'b1;
    disp(3, 5, 10, 32'h10, 2, 1'b0, 0);
    sample();
    check("t1_disp_ready", 32'(bus.dispatch_ready), 32'd1);
    check("t1_no_issue_yet", 32'(bus.issue_valid), 32'd0);
    cyc();
    bus.dispatch_valid = 1'b0;
    sample();
    check("t1_issue_valid", 32'(bus.issue_valid), 32'd1);
    check("t1_rob", 32'(bus.issue_rob_num), 32'd3);
    check("t1_ps1", 32'(bus.issue_ps1), 32'd5);
    check("t1_pd", 32'(bus.issue_pd), 32'd10);
    check("t1_imm", bus.issue_imm, 32'h10);
    check("t1_funct3", 32'(bus.issue_funct3), 32'd2);
    check("t1_occ", 32'(bus.occupancy), 32'd1);
    cyc();
    sample();
    check("t1_freed_valid", 32'(bus.issue_valid), 32'd0);
    check("t1_freed_occ", 32'(bus.occupancy), 32'd0);
    cyc();

    // Store dependency, then base register
    bus.valid_reg = '0;
    disp(4, 20, 11, 32'hFFFF_FFF8, 0, 1'b1, 2);
    sample();
    cyc();
    bus.dispatch_valid = 1'b0;
    bus.sl_cdb_valid = 1'b1;
    bus.sl_cdb_rob_num = 5'd2;
    sample();
    check("t2_t_valid", 32'(bus.issue_valid), 32'd0);
    check("t2_t_occ", 32'(bus.occupancy), 32'd1);
    cyc();
    bus.sl_cdb_valid = 1'b0;
    sample();
    check("t2_t1_valid", 32'(bus.issue_valid), 32'd0);
    cyc();
    bus.valid_reg[20] = 1'b1;
    sample();
    check("t2_t2_valid", 32'(bus.issue_valid), 32'd0);
    cyc();
    sample();
    check("t2_t3_valid", 32'(bus.issue_valid), 32'd1);
    check("t2_t3_rob", 32'(bus.issue_rob_num), 32'd4);
    check("t2_t3_imm", bus.issue_imm, 32'hFFFF_FFF8);
    cyc();
    sample();
    check("t2_done_occ", 32'(bus.occupancy), 32'd0);
    cyc();

    // CDB matches the store dependency in the dispatch cycle
    bus.valid_reg = '0;
    bus.valid_reg[7] = 1'b1;
    disp(6, 7, 12, 32'h4, 4, 1'b1, 5);
    bus.sl_cdb_valid = 1'b1;
    bus.sl_cdb_rob_num = 5'd5;
    sample();
    check("t3_no_issue_yet", 32'(bus.issue_valid), 32'd0);
    cyc();
    bus.dispatch_valid = 1'b0;
    bus.sl_cdb_valid = 1'b0;
    sample();
    check("t3_issue_valid", 32'(bus.issue_valid), 32'd1);
    check("t3_rob", 32'(bus.issue_rob_num), 32'd6);
    cyc();
    sample();
    check("t3_done_occ", 32'(bus.occupancy), 32'd0);
    cyc();

    // Fill all slots; fifth load must be refused
    bus.issue_ready = 1'b0;
    bus.valid_reg = '0;
    disp(8, 30, 1, 32'h0, 2, 1'b0, 0);
    cyc();
    disp(10, 31, 2, 32'h0, 2, 1'b0, 0);
    cyc();
    disp(7, 32, 3, 32'h0, 2, 1'b0, 0);
    cyc();
    disp(11, 33, 4, 32'h0, 2, 1'b0, 0);
    cyc();
    disp(12, 34, 5, 32'h0, 2, 1'b0, 0);
    sample();
    check("t4_full_ready", 32'(bus.dispatch_ready), 32'd0);
    check("t4_full_occ", 32'(bus.occupancy), 32'd4);
    cyc();
    sample();
    check("t4_full_ready2", 32'(bus.dispatch_ready), 32'd0);
    check("t4_full_occ2", 32'(bus.occupancy), 32'd4);
    check("t4_full_noissue", 32'(bus.issue_valid), 32'd0);
    cyc();
    // Drain slot 0 so a younger load lands below an older one
    bus.dispatch_valid = 1'b0;
    bus.valid_reg[30] = 1'b1;
    bus.issue_ready = 1'b1;
    sample();
    check("t4_wake_pending", 32'(bus.issue_valid), 32'd0);
    cyc();
    sample();
    check("t4_s0_valid", 32'(bus.issue_valid), 32'd1);
    check("t4_s0_rob", 32'(bus.issue_rob_num), 32'd8);
    cyc();
    bus.valid_reg[30] = 1'b0;
    bus.issue_ready = 1'b0;
    disp(9, 35, 6, 32'h0, 2, 1'b0, 0);
    sample();
    check("t4_reopen_ready", 32'(bus.dispatch_ready), 32'd1);
    check("t4_reopen_occ", 32'(bus.occupancy), 32'd3);
    cyc();
    bus.dispatch_valid = 1'b0;
    bus.valid_reg[32] = 1'b1;
    bus.valid_reg[35] = 1'b1;
    sample();
    check("t4_refill_occ", 32'(bus.occupancy), 32'd4);
    cyc();
    sample();
    check("t4_old_valid", 32'(bus.issue_valid), 32'd1);
    check("t4_old_rob", 32'(bus.issue_rob_num), 32'd7);
    cyc();
    bus.issue_ready = 1'b1;
    sample();
    check("t4_iss1_rob", 32'(bus.issue_rob_num), 32'd7);
    cyc();
    sample();
    check("t4_iss2_valid", 32'(bus.issue_valid), 32'd1);
    check("t4_iss2_rob", 32'(bus.issue_rob_num), 32'd9);
    cyc();
    bus.issue_ready = 1'b0;
    sample();
    check("t4_after_valid", 32'(bus.issue_valid), 32'd0);
    check("t4_after_occ", 32'(bus.occupancy), 32'd2);
    cyc();

    // Flush with three occupied slots and a concurrent dispatch
    disp(13, 36, 7, 32'h0, 2, 1'b0, 0);
    sample();
    cyc();
    bus.dispatch_valid = 1'b0;
    bus.valid_reg[31] = 1'b1;
    sample();
    check("t5_pre_occ", 32'(bus.occupancy), 32'd3);
    cyc();
    sample();
    check("t5_pre_valid", 32'(bus.issue_valid), 32'd1);
    check("t5_pre_rob", 32'(bus.issue_rob_num), 32'd10);
    cyc();
    bus.flush = 1'b1;
    bus.issue_ready = 1'b1;
    bus.valid_reg[37] = 1'b1;
    disp(14, 37, 8, 32'h0, 2, 1'b0, 0);
    sample();
    check("t5_flush_valid", 32'(bus.issue_valid), 32'd0);
    check("t5_flush_occ", 32'(bus.occupancy), 32'd3);
    cyc();
    bus.flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    sample();
    check("t5_post_occ", 32'(bus.occupancy), 32'd0);
    check("t5_post_valid", 32'(bus.issue_valid), 32'd0);
    check("t5_post_ready", 32'(bus.dispatch_ready), 32'd1);
    cyc();
    sample();
    check("t5_dropped_valid", 32'(bus.issue_valid), 32'd0);
    check("t5_dropped_occ", 32'(bus.occupancy), 32'd0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
